// File: rtl/md_sched.sv
// md_sched: sequences the shared HI/LO multiply/divide unit in the E stage
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   md_op_E    E-stage op: 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo,9-15 none
//   rs_E/rt_E  forwarded operands of the E-stage instruction
//   md_use_D   D-stage instruction is a HI/LO op
//   exc_flush  CP0 takes an exception/interrupt this cycle
//   start      mult/div accepted this cycle
//   busy       operation in flight
//   stall_D    freeze D while a HI/LO op would collide with a running operation
//   hi/lo      architectural HI/LO
//   md_rd_E    mfhi/mflo read data, zero otherwise
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    input  logic        exc_flush,
    output logic        start,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rd_E
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0] a, b, hi_nx, lo_nx;
    logic sgn, is_div, done;
    logic [63:0] ax, bx, prod;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, quo, rem;
    assign is_div  = md_op_E == 4'd3 || md_op_E == 4'd4;
    assign start   = !reset && state == IDLE && md_op_E >= 4'd1 && md_op_E <= 4'd4 && !exc_flush;
    assign busy    = state != IDLE;
    assign stall_D = md_use_D && (start || busy);
    assign done    = cnt == CW'(1);
    assign md_rd_E = md_op_E == 4'd7 ? hi : md_op_E == 4'd8 ? lo : 32'd0;
    // Sign-extend only for signed ops; the low 64 bits of the product are then correct either way.
    assign ax    = {{32{sgn & a[31]}}, a};
    assign bx    = {{32{sgn & b[31]}}, b};
    assign prod  = ax * bx;
    // Signed divide on magnitudes; quotient sign from operand signs, remainder follows the dividend.
    assign abs_a = sgn && a[31] ? -a : a;
    assign abs_b = sgn && b[31] ? -b : b;
    assign q_mag = abs_a / abs_b;
    assign r_mag = abs_a % abs_b;
    assign quo   = sgn && (a[31] ^ b[31]) ? -q_mag : q_mag;
    assign rem   = sgn && a[31] ? -r_mag : r_mag;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hi_nx    = hi;
        lo_nx    = lo;
        if (start) begin
            state_nx = is_div ? DIV : MUL;
            cnt_nx   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (busy) begin
            cnt_nx = cnt - CW'(1);
            if (done) begin
                state_nx = IDLE;
                hi_nx    = state == MUL ? prod[63:32] : b != 32'd0 ? rem : hi;
                lo_nx    = state == MUL ? prod[31:0]  : b != 32'd0 ? quo : lo;
            end
        end else if (!exc_flush) begin
            hi_nx = md_op_E == 4'd5 ? rs_E : hi;
            lo_nx = md_op_E == 4'd6 ? rs_E : lo;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            a     <= '0;
            b     <= '0;
            sgn   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
            if (start) begin
                a   <= rs_E;
                b   <= rt_E;
                sgn <= md_op_E == 4'd1 || md_op_E == 4'd3;
            end
        end
    end
endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] md_op_E = '0;
    logic [31:0] rs_E = '0, rt_E = '0;
    logic md_use_D = 1'b0, exc_flush = 1'b0;
    logic start, busy, stall_D;
    logic [31:0] hi, lo, md_rd_E;
    int tests = 0, fails = 0;
    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs, rt, hi, lo;
        int          lat;
    } vec_t;
    typedef struct {
        logic [31:0] hi, lo;
        int          lat;
    } exp_t;
    exp_t sb[$];
    vec_t vt[13];

    md_sched dut (
        .clk(clk), .reset(reset), .md_op_E(md_op_E), .rs_E(rs_E), .rt_E(rt_E),
        .md_use_D(md_use_D), .exc_flush(exc_flush), .start(start), .busy(busy),
        .stall_D(stall_D), .hi(hi), .lo(lo), .md_rd_E(md_rd_E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        int n;
        @(negedge clk);
        md_op_E = v.op;
        rs_E = v.rs;
        rt_E = v.rt;
        #1 chk("start", start, v.op >= 1 && v.op <= 4);
        sb.push_back('{v.hi, v.lo, v.lat});
        @(posedge clk);
        #1 md_op_E = '0;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            e = sb.pop_front();
            chk("latency", n, e.lat);
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
            md_op_E = 4'd7;
            #1 chk("mfhi", md_rd_E, e.hi);
            md_op_E = 4'd8;
            #1 chk("mflo", md_rd_E, e.lo);
            md_op_E = 4'd0;
            #1 chk("rd_none", md_rd_E, 0);
        end
    endtask

    initial begin
        int n;
        vt[0]  = '{4'd1,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vt[1]  = '{4'd2,  32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vt[2]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[3]  = '{4'd4,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[4]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vt[5]  = '{4'd4,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vt[6]  = '{4'd3,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vt[7]  = '{4'd1,  32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};
        vt[8]  = '{4'd5,  32'h12345678, 32'd0,        32'h12345678, 32'd0,        0};
        vt[9]  = '{4'd6,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        vt[10] = '{4'd12, 32'd55,       32'd66,       32'h12345678, 32'h9ABCDEF0, 0};
        vt[11] = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vt[12] = '{4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        md_op_E = 4'd1;
        md_use_D = 1'b1;
        rs_E = 32'd3;
        rt_E = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", start, 0);
        chk("rst_stall", stall_D, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        md_op_E = '0;
        md_use_D = 1'b0;

        for (int i = 0; i < 13; i++) apply(vt[i]);

        @(negedge clk);
        md_use_D = 1'b1;
        md_op_E = 4'd1;
        rs_E = 32'd3;
        rt_E = 32'd5;
        #1;
        chk("stall_start", stall_D, 1);
        @(posedge clk);
        #1 md_op_E = 4'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_busy", {busy, stall_D}, 2'b11);
        end
        @(negedge clk);
        chk("stall_drop", {busy, stall_D}, 2'b00);
        chk("mflo_after", md_rd_E, 15);
        md_op_E = '0;
        md_use_D = 1'b0;

        @(negedge clk);
        exc_flush = 1'b1;
        md_op_E = 4'd1;
        rs_E = 32'd1000;
        rt_E = 32'd1000;
        #1 chk("flush_start", start, 0);
        @(posedge clk);
        #1 chk("flush_busy", busy, 0);
        md_op_E = 4'd6;
        rs_E = 32'hDEADBEEF;
        @(posedge clk);
        #1 chk("flush_hi", hi, 0);
        chk("flush_lo", lo, 15);
        md_op_E = '0;
        exc_flush = 1'b0;

        @(negedge clk);
        md_op_E = 4'd1;
        rs_E = 32'd4;
        rt_E = 32'd5;
        @(posedge clk);
        #1 md_op_E = '0;
        exc_flush = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        exc_flush = 1'b0;
        chk("flushbusy_lat", n, 5);
        chk("flushbusy_lo", lo, 20);

        @(negedge clk);
        md_op_E = 4'd3;
        rs_E = 32'd100;
        rt_E = 32'd7;
        @(posedge clk);
        #1 md_op_E = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("abort_late_busy", busy, 0);
        chk("abort_late_hilo", {hi, lo}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
